// File: rtl/eye_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : eye_pkg
//  Purpose  : Shared widths, frame-size defaults and FSM encoding for the
//             eye bounding-box measurement block.
//  Revision : 1.0  initial release
// ============================================================================
package eye_pkg;

  localparam int POS_W      = 11;
  localparam int CNT_W      = 16;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_V_DISP = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CALC = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/minmax_track.sv
`default_nettype none
// ============================================================================
//  Module   : minmax_track
//  Purpose  : Running minimum/maximum of one coordinate. Clear together with
//             update seeds both registers with the incoming value.
//  Revision : 1.0  initial release
// ============================================================================
module minmax_track #(
  parameter int W = 11
) (
  input  logic         module_clk,
  input  logic         module_rst_n,
  input  logic         clear,
  input  logic         update,
  input  logic [W-1:0] value,
  output logic [W-1:0] min_val,
  output logic [W-1:0] max_val
);

  logic [W-1:0] r_min;
  logic [W-1:0] r_max;

  always_ff @(posedge module_clk) begin
    if (!module_rst_n || (clear && !update)) begin
      r_min <= '1;
      r_max <= '0;
    end else if (clear) begin
      r_min <= value;
      r_max <= value;
    end else if (update) begin
      if (value < r_min) r_min <= value;
      if (value > r_max) r_max <= value;
    end
  end

  assign min_val = r_min;
  assign max_val = r_max;

endmodule
`default_nettype wire

// File: rtl/eye_bbox_measure.sv
`default_nettype none
// ============================================================================
//  Module   : eye_bbox_measure
//  Purpose  : Tracks the bounding box of dark pixels inside a fixed ROI and
//             publishes height/width once per frame for the PERCLOS stage.
//  Revision : 1.0  initial release
// ============================================================================
module eye_bbox_measure
  import eye_pkg::*;
#(
  parameter int H_DISP  = DEF_H_DISP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int ROI_X0  = 200,
  parameter int ROI_X1  = 440,
  parameter int ROI_Y0  = 120,
  parameter int ROI_Y1  = 360,
  parameter int MIN_PIX = 16
) (
  input  logic             module_clk,
  input  logic             module_rst_n,
  input  logic [POS_W-1:0] lcd_pixel_xpos,
  input  logic [POS_W-1:0] lcd_pixel_ypos,
  input  logic             pixel_bin,
  output logic [POS_W-1:0] eye_high,
  output logic [POS_W-1:0] eye_wide,
  output logic             bbox_valid,
  output logic             frame_done
);

  localparam logic [POS_W-1:0] C_ONE     = POS_W'(1);
  localparam logic [POS_W-1:0] C_H_DISP  = POS_W'(H_DISP);
  localparam logic [POS_W-1:0] C_V_DISP  = POS_W'(V_DISP);
  localparam logic [POS_W-1:0] C_ROI_X0  = POS_W'(ROI_X0);
  localparam logic [POS_W-1:0] C_ROI_X1  = POS_W'(ROI_X1);
  localparam logic [POS_W-1:0] C_ROI_Y0  = POS_W'(ROI_Y0);
  localparam logic [POS_W-1:0] C_ROI_Y1  = POS_W'(ROI_Y1);
  localparam logic [CNT_W-1:0] C_MIN_PIX = CNT_W'(MIN_PIX);

  state_t             r_state;
  state_t             w_state_next;
  logic [POS_W-1:0]   r_prev_x;
  logic [POS_W-1:0]   r_prev_y;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic               w_new_pos;
  logic               w_fs;
  logic               w_fe;
  logic               w_hit;
  logic               w_clear;
  logic               w_update;
  logic               w_calc;
  logic [POS_W-1:0]   w_x_min;
  logic [POS_W-1:0]   w_x_max;
  logic [POS_W-1:0]   w_y_min;
  logic [POS_W-1:0]   w_y_max;

  // Markers fire only on the first cycle a position is presented; the
  // previous-position register resets to 0, which is never a legal position.
  assign w_new_pos = (lcd_pixel_xpos != r_prev_x) || (lcd_pixel_ypos != r_prev_y);
  assign w_fs      = w_new_pos && (lcd_pixel_xpos == C_ONE) && (lcd_pixel_ypos == C_ONE);
  assign w_fe      = w_new_pos && (lcd_pixel_xpos == C_H_DISP) && (lcd_pixel_ypos == C_V_DISP);
  assign w_hit     = w_new_pos && pixel_bin &&
                     (lcd_pixel_xpos >= C_ROI_X0) && (lcd_pixel_xpos <= C_ROI_X1) &&
                     (lcd_pixel_ypos >= C_ROI_Y0) && (lcd_pixel_ypos <= C_ROI_Y1);

  always_ff @(posedge module_clk) begin
    if (!module_rst_n) begin
      r_state  <= ST_IDLE;
      r_prev_x <= '0;
      r_prev_y <= '0;
    end else begin
      r_state  <= w_state_next;
      r_prev_x <= lcd_pixel_xpos;
      r_prev_y <= lcd_pixel_ypos;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_update     = 1'b0;
    w_calc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (w_fs) begin
          w_update     = w_hit;
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_update = w_hit;
        if (w_fs) begin
          w_clear = 1'b1;
        end else if (w_fe) begin
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_calc  = 1'b1;
        w_clear = 1'b1;
        if (w_fs) begin
          w_update     = w_hit;
          w_state_next = ST_SCAN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  minmax_track #(.W(POS_W)) u_track_x (
    .module_clk   (module_clk),
    .module_rst_n (module_rst_n),
    .clear        (w_clear),
    .update       (w_update),
    .value        (lcd_pixel_xpos),
    .min_val      (w_x_min),
    .max_val      (w_x_max)
  );

  minmax_track #(.W(POS_W)) u_track_y (
    .module_clk   (module_clk),
    .module_rst_n (module_rst_n),
    .clear        (w_clear),
    .update       (w_update),
    .value        (lcd_pixel_ypos),
    .min_val      (w_y_min),
    .max_val      (w_y_max)
  );

  always_ff @(posedge module_clk) begin
    if (!module_rst_n || (w_clear && !w_update)) begin
      r_pix_cnt <= '0;
    end else if (w_clear) begin
      r_pix_cnt <= CNT_W'(1);
    end else if (w_update && (r_pix_cnt != '1)) begin
      r_pix_cnt <= r_pix_cnt + CNT_W'(1);
    end
  end

  // Height falls back to 1 on an invalid frame so the downstream divide is safe.
  always_ff @(posedge module_clk) begin
    if (!module_rst_n) begin
      eye_high   <= C_ONE;
      eye_wide   <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_calc;
      if (w_calc) begin
        if (r_pix_cnt >= C_MIN_PIX) begin
          eye_wide   <= w_x_max - w_x_min + C_ONE;
          eye_high   <= w_y_max - w_y_min + C_ONE;
          bbox_valid <= 1'b1;
        end else begin
          eye_wide   <= '0;
          eye_high   <= C_ONE;
          bbox_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eye_bbox_measure.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_eye_bbox_measure
//  Purpose  : Directed raster frames on a reduced display size; expected
//             results are queued at frame end and popped on frame_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eye_bbox_measure;

  localparam int HD  = 64;
  localparam int VD  = 48;
  localparam int RX0 = 20;
  localparam int RX1 = 44;
  localparam int RY0 = 12;
  localparam int RY1 = 36;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] xpos  = '0;
  logic [10:0] ypos  = '0;
  logic        pix   = 1'b0;
  logic [10:0] high_a, wide_a, high_b, wide_b;
  logic        valid_a, done_a, valid_b, done_b;

  always #5 clk = ~clk;

  eye_bbox_measure #(.H_DISP(HD), .V_DISP(VD), .ROI_X0(RX0), .ROI_X1(RX1),
                     .ROI_Y0(RY0), .ROI_Y1(RY1), .MIN_PIX(16)) dut_a (
    .module_clk(clk), .module_rst_n(rst_n), .lcd_pixel_xpos(xpos),
    .lcd_pixel_ypos(ypos), .pixel_bin(pix), .eye_high(high_a),
    .eye_wide(wide_a), .bbox_valid(valid_a), .frame_done(done_a));

  eye_bbox_measure #(.H_DISP(HD), .V_DISP(VD), .ROI_X0(RX0), .ROI_X1(RX1),
                     .ROI_Y0(RY0), .ROI_Y1(RY1), .MIN_PIX(1)) dut_b (
    .module_clk(clk), .module_rst_n(rst_n), .lcd_pixel_xpos(xpos),
    .lcd_pixel_ypos(ypos), .pixel_bin(pix), .eye_high(high_b),
    .eye_wide(wide_b), .bbox_valid(valid_b), .frame_done(done_b));

  typedef struct {
    int          cyc;
    logic [10:0] ha, wa, hb, wb;
    logic        va, vb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   pulses = 0;
  logic prev_done_a = 1'b0;

  int nr;
  int rx0[12], rx1[12], ry0[12], ry1[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done_a || done_b) begin
      pulses++;
      check("done_pulse_width", int'(prev_done_a), 0);
      check("done_a", int'(done_a), 1);
      check("done_b", int'(done_b), 1);
      check("frame_done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("high_a", int'(high_a), int'(e.ha));
        check("wide_a", int'(wide_a), int'(e.wa));
        check("valid_a", int'(valid_a), int'(e.va));
        check("high_b", int'(high_b), int'(e.hb));
        check("wide_b", int'(wide_b), int'(e.wb));
        check("valid_b", int'(valid_b), int'(e.vb));
      end
    end
    prev_done_a = done_a;
  end

  task automatic set_rect(input int i, input int xa, input int xb, input int ya, input int yb);
    rx0[i] = xa; rx1[i] = xb; ry0[i] = ya; ry1[i] = yb;
  endtask

  // Raster rows first_row..last_row; on the frame-end pixel the reference
  // box for both MIN_PIX settings is queued when expect_done is set.
  task automatic run_frame(input int first_row, input int last_row, input bit expect_done);
    int   mnx, mxx, mny, mxy, cnt;
    bit   dark;
    exp_t e;
    mnx = 2047; mxx = 0; mny = 2047; mxy = 0; cnt = 0;
    for (int y = first_row; y <= last_row; y++) begin
      for (int x = 1; x <= HD; x++) begin
        dark = 1'b0;
        for (int r = 0; r < nr; r++)
          if (x >= rx0[r] && x <= rx1[r] && y >= ry0[r] && y <= ry1[r]) dark = 1'b1;
        @(posedge clk);
        #1;
        xpos = x[10:0];
        ypos = y[10:0];
        pix  = dark;
        if (dark && x >= RX0 && x <= RX1 && y >= RY0 && y <= RY1) begin
          cnt++;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
        if (expect_done && x == HD && y == VD) begin
          e.cyc = cyc + 2;
          if (cnt >= 16) begin
            e.ha = 11'(mxy - mny + 1); e.wa = 11'(mxx - mnx + 1); e.va = 1'b1;
          end else begin
            e.ha = 11'd1; e.wa = 11'd0; e.va = 1'b0;
          end
          if (cnt >= 1) begin
            e.hb = 11'(mxy - mny + 1); e.wb = 11'(mxx - mnx + 1); e.vb = 1'b1;
          end else begin
            e.hb = 11'd1; e.wb = 11'd0; e.vb = 1'b0;
          end
          sb.push_back(e);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_high_a", int'(high_a), 1);
    check("rst_wide_a", int'(wide_a), 0);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_high_b", int'(high_b), 1);
    check("rst_valid_b", int'(valid_b), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // box 20x10 inside ROI
    nr = 1; set_rect(0, 22, 41, 20, 29);
    run_frame(1, VD, 1);
    // all light
    nr = 0;
    run_frame(1, VD, 1);
    // ten isolated ROI pixels plus a big block left of the ROI
    nr = 11;
    for (int i = 0; i < 10; i++) set_rect(i, 21 + 2 * i, 21 + 2 * i, 13 + 2 * i, 13 + 2 * i);
    set_rect(10, 5, 10, 1, VD);
    run_frame(1, VD, 1);
    // top-left ROI corner, neighbours just outside
    nr = 3; set_rect(0, 20, 20, 12, 12); set_rect(1, 19, 19, 12, 12); set_rect(2, 20, 20, 11, 11);
    run_frame(1, VD, 1);
    // bottom-right ROI corner, neighbours just outside
    nr = 3; set_rect(0, 44, 44, 36, 36); set_rect(1, 45, 45, 36, 36); set_rect(2, 44, 44, 37, 37);
    run_frame(1, VD, 1);

    // frame A, truncated frame, frame B
    nr = 1; set_rect(0, 22, 41, 20, 29);
    run_frame(1, VD, 1);
    nr = 1; set_rect(0, RX0, RX1, RY0, RY1);
    run_frame(1, 30, 0);
    @(negedge clk);
    check("hold_high_a", int'(high_a), 10);
    check("hold_wide_a", int'(wide_a), 20);
    check("hold_valid_a", int'(valid_a), 1);
    nr = 1; set_rect(0, 30, 39, 14, 33);
    run_frame(1, VD, 1);

    // reset in the middle of a frame with a dark box
    nr = 1; set_rect(0, 22, 41, 20, 29);
    run_frame(1, 25, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_high_a", int'(high_a), 1);
    check("midrst_wide_a", int'(wide_a), 0);
    check("midrst_valid_a", int'(valid_a), 0);
    check("midrst_wide_b", int'(wide_b), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(26, VD, 0);

    nr = 1; set_rect(0, 25, 30, 15, 35);
    run_frame(1, VD, 1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("frame_done_count", pulses, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
